// File: rtl/uart_tx_arbiter.sv
// Two-client packet arbiter in front of a UART transmit FIFO.
// Round-robin on ties, grant held for a whole packet, revoked if the owner stalls too long.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       tx_full,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic [1:0] grant,
   output logic       abort
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 32'd1);

   state_t      state_q;
   state_t      state_d;
   logic        last_owner_q;
   logic        last_owner_d;
   logic [15:0] idle_cnt_q;
   logic [15:0] idle_cnt_d;
   logic        abort_q;
   logic        abort_d;

   logic        sel_valid;
   logic        sel_last;
   logic [7:0]  sel_data;
   logic        xfer;

   // Route the currently granted client's request onto a common bus.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      case (state_q)
         GNT0: begin
            sel_valid = req0_valid;
            sel_last  = req0_last;
            sel_data  = req0_data;
         end
         GNT1: begin
            sel_valid = req1_valid;
            sel_last  = req1_last;
            sel_data  = req1_data;
         end
         default: begin
            sel_valid = 1'b0;
            sel_last  = 1'b0;
            sel_data  = 8'h00;
         end
      endcase
      // A byte offered while reset is high is never written.
      xfer = sel_valid & ~tx_full & ~reset;
   end

   // Next-state, round-robin history and idle-counter update.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      idle_cnt_d   = idle_cnt_q;
      abort_d      = 1'b0;
      case (state_q)
         IDLE: begin
            idle_cnt_d = 16'd0;
            if (req0_valid && req1_valid) begin
               state_d = last_owner_q ? GNT0 : GNT1;
            end else if (req0_valid) begin
               state_d = GNT0;
            end else if (req1_valid) begin
               state_d = GNT1;
            end else begin
               state_d = IDLE;
            end
         end
         GNT0, GNT1: begin
            if (xfer) begin
               idle_cnt_d = 16'd0;
               if (sel_last) begin
                  state_d      = IDLE;
                  last_owner_d = (state_q == GNT1);
               end else begin
                  state_d = state_q;
               end
            end else if (!sel_valid) begin
               if (idle_cnt_q == TIMEOUT_M1) begin
                  state_d      = IDLE;
                  last_owner_d = (state_q == GNT1);
                  idle_cnt_d   = 16'd0;
                  abort_d      = 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + 16'd1;
               end
            end else begin
               // Stalled by a full FIFO with data pending: not an idle cycle.
               idle_cnt_d = idle_cnt_q;
            end
         end
         default: begin
            state_d    = IDLE;
            idle_cnt_d = 16'd0;
         end
      endcase
   end

   // State, round-robin history, idle counter and abort pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         idle_cnt_q   <= 16'd0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         idle_cnt_q   <= idle_cnt_d;
         abort_q      <= abort_d;
      end
   end

   // Client handshakes and FIFO write port, decoded from the registered state.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant      = 2'b00;
      case (state_q)
         GNT0: begin
            grant      = 2'b01;
            req0_ready = ~tx_full & ~reset;
         end
         GNT1: begin
            grant      = 2'b10;
            req1_ready = ~tx_full & ~reset;
         end
         default: begin
            grant = 2'b00;
         end
      endcase
      wr_uart = xfer;
      w_data  = xfer ? sel_data : 8'h00;
   end

   assign abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle comparison against a packet-level model,
// plus hand-computed write/grant/abort timelines for each scenario.
module tb_uart_tx_arbiter;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req1_valid, req1_last, tx_full;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready, wr_uart, abort;
   logic [7:0] w_data;
   logic [1:0] grant;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model: who owns the UART (-1 nobody), who finished last, idle cycles seen, abort due.
   int m_owner = -1;
   int m_last = 1;
   int m_idle = 0;
   bit m_abort = 1'b0;
   bit m_known = 1'b0;

   logic [7:0] w_log[$];
   int         w_cyc[$];
   int         ab_cyc[$];
   logic [1:0] g_hist[int];

   uart_tx_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .grant(grant), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      w_log.delete();
      w_cyc.delete();
      ab_cyc.delete();
   endtask

   // Per-cycle comparison of every output against the model, plus observation logs.
   always @(negedge clk) begin
      bit         own_v;
      bit         exp_wr;
      logic [7:0] own_d;
      logic [7:0] exp_d;
      logic [1:0] exp_g;
      own_v = (m_owner == 0) ? req0_valid : (m_owner == 1) ? req1_valid : 1'b0;
      own_d = (m_owner == 0) ? req0_data : (m_owner == 1) ? req1_data : 8'h00;
      exp_wr = !reset && own_v && !tx_full;
      exp_d = exp_wr ? own_d : 8'h00;
      exp_g = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      if (m_known) begin
         check("grant", 32'(grant), 32'(exp_g));
         check("req0_ready", 32'(req0_ready), 32'(!reset && m_owner == 0 && !tx_full));
         check("req1_ready", 32'(req1_ready), 32'(!reset && m_owner == 1 && !tx_full));
         check("wr_uart", 32'(wr_uart), 32'(exp_wr));
         check("w_data", 32'(w_data), 32'(exp_d));
         check("abort", 32'(abort), 32'(m_abort));
      end
      g_hist[cyc] = grant;
      if (wr_uart === 1'b1) begin
         w_log.push_back(w_data);
         w_cyc.push_back(cyc);
      end
      if (abort === 1'b1) ab_cyc.push_back(cyc);
   end

   // Model advance on each rising edge from the inputs held during the cycle.
   always @(posedge clk) begin
      bit own_v;
      bit own_l;
      bit ab;
      cyc++;
      ab = 1'b0;
      if (reset) begin
         m_known = 1'b1;
         m_owner = -1;
         m_last = 1;
         m_idle = 0;
         m_abort = 1'b0;
      end else if (m_known) begin
         if (m_owner < 0) begin
            if (req0_valid && req1_valid) m_owner = 1 - m_last;
            else if (req0_valid) m_owner = 0;
            else if (req1_valid) m_owner = 1;
            m_idle = 0;
         end else begin
            own_v = (m_owner == 0) ? req0_valid : req1_valid;
            own_l = (m_owner == 0) ? req0_last : req1_last;
            if (own_v && !tx_full) begin
               m_idle = 0;
               if (own_l) begin
                  m_last = m_owner;
                  m_owner = -1;
               end
            end else if (!own_v) begin
               if (m_idle + 1 == TO) begin
                  ab = 1'b1;
                  m_last = m_owner;
                  m_owner = -1;
                  m_idle = 0;
               end else begin
                  m_idle++;
               end
            end
         end
         m_abort = ab;
      end
   end

   initial begin
      int t0;
      reset = 1'b1;
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      tx_full = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #2;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_wr", 32'(wr_uart), 32'd0);
      check("rst_wdata", 32'(w_data), 32'd0);
      check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("rst_abort", 32'(abort), 32'd0);

      // Client 0 packet 55, AA(last).
      tick(); clear_logs(); t0 = cyc;
      req0_valid = 1'b1; req0_data = 8'h55;
      tick();
      tick(); req0_data = 8'hAA; req0_last = 1'b1;
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      check("s1_nwr", w_log.size(), 32'd2);
      check("s1_b0", 32'(w_log[0]), 32'h55);
      check("s1_b1", 32'(w_log[1]), 32'hAA);
      check("s1_c0", w_cyc[0] - t0, 32'd1);
      check("s1_c1", w_cyc[1] - t0, 32'd2);
      check("s1_g0", 32'(g_hist[t0]), 32'd0);
      check("s1_g1", 32'(g_hist[t0 + 1]), 32'd1);
      check("s1_g3", 32'(g_hist[t0 + 3]), 32'd0);

      // Tie straight after reset: client 0 first, then client 1.
      reset = 1'b1; tick(); reset = 1'b0;
      clear_logs(); t0 = cyc;
      req0_valid = 1'b1; req0_data = 8'hF0; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h0F; req1_last = 1'b1;
      tick();
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      tick(); req1_valid = 1'b0; req1_last = 1'b0;
      tick();
      check("s2_nwr", w_log.size(), 32'd2);
      check("s2_b0", 32'(w_log[0]), 32'hF0);
      check("s2_b1", 32'(w_log[1]), 32'h0F);
      check("s2_c1", w_cyc[1] - t0, 32'd3);
      check("s2_g1", 32'(g_hist[t0 + 1]), 32'd1);
      check("s2_g2", 32'(g_hist[t0 + 2]), 32'd0);
      check("s2_g3", 32'(g_hist[t0 + 3]), 32'd2);

      // 50-cycle FIFO-full stall mid-packet with valid held.
      clear_logs(); t0 = cyc;
      req0_valid = 1'b1; req0_data = 8'h11;
      tick();
      tick(); req0_data = 8'h22; req0_last = 1'b1; tx_full = 1'b1;
      repeat (50) tick();
      tx_full = 1'b0;
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      check("s3_nwr", w_log.size(), 32'd2);
      check("s3_b1", 32'(w_log[1]), 32'h22);
      check("s3_c1", w_cyc[1] - t0, 32'd52);
      check("s3_noab", ab_cyc.size(), 32'd0);

      // Timeout: client 1 goes silent after FF, client 0 waiting.
      clear_logs(); t0 = cyc;
      req1_valid = 1'b1; req1_data = 8'hFF;
      tick();
      tick(); req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h33; req0_last = 1'b1;
      repeat (10) tick();
      req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      check("s4_nab", ab_cyc.size(), 32'd1);
      check("s4_abc", ab_cyc[0] - t0, 32'd10);
      check("s4_g9", 32'(g_hist[t0 + 9]), 32'd2);
      check("s4_g10", 32'(g_hist[t0 + 10]), 32'd0);
      check("s4_g11", 32'(g_hist[t0 + 11]), 32'd1);
      check("s4_b1", 32'(w_log[1]), 32'h33);
      check("s4_c1", w_cyc[1] - t0, 32'd11);

      // Valid returns exactly at the last idle cycle: transfer wins, no abort.
      clear_logs(); t0 = cyc;
      req1_valid = 1'b1; req1_data = 8'hFE;
      tick();
      tick(); req1_valid = 1'b0;
      repeat (7) tick();
      req1_valid = 1'b1; req1_data = 8'hEF; req1_last = 1'b1;
      tick(); req1_valid = 1'b0; req1_last = 1'b0;
      tick();
      check("s5_noab", ab_cyc.size(), 32'd0);
      check("s5_nwr", w_log.size(), 32'd2);
      check("s5_c1", w_cyc[1] - t0, 32'd9);

      // Client 0 streams 01..04 while client 1 waits.
      clear_logs(); t0 = cyc;
      req0_valid = 1'b1; req0_data = 8'h01;
      req1_valid = 1'b1; req1_data = 8'hA1; req1_last = 1'b1;
      tick();
      tick(); req0_data = 8'h02;
      tick(); req0_data = 8'h03;
      tick(); req0_data = 8'h04; req0_last = 1'b1;
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      tick(); req1_valid = 1'b0; req1_last = 1'b0;
      tick();
      check("s6_nwr", w_log.size(), 32'd5);
      check("s6_b3", 32'(w_log[3]), 32'h04);
      check("s6_b4", 32'(w_log[4]), 32'hA1);
      check("s6_c4", w_cyc[4] - t0, 32'd6);
      check("s6_g5", 32'(g_hist[t0 + 5]), 32'd0);
      check("s6_g6", 32'(g_hist[t0 + 6]), 32'd2);

      // Make client 0 the last owner, then reset mid-packet.
      req0_valid = 1'b1; req0_data = 8'hB0; req0_last = 1'b1;
      tick();
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      clear_logs(); t0 = cyc;
      req0_valid = 1'b1; req0_data = 8'hC1;
      tick();
      tick(); req0_data = 8'hC2; reset = 1'b1;
      tick(); reset = 1'b0;
      req0_data = 8'hD0; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = 8'hD1; req1_last = 1'b1;
      tick();
      tick(); req0_valid = 1'b0; req0_last = 1'b0;
      tick();
      tick(); req1_valid = 1'b0; req1_last = 1'b0;
      tick();
      check("s7_nwr", w_log.size(), 32'd3);
      check("s7_b0", 32'(w_log[0]), 32'hC1);
      check("s7_b1", 32'(w_log[1]), 32'hD0);
      check("s7_b2", 32'(w_log[2]), 32'hD1);
      check("s7_noab", ab_cyc.size(), 32'd0);
      check("s7_g3", 32'(g_hist[t0 + 3]), 32'd0);
      check("s7_g4", 32'(g_hist[t0 + 4]), 32'd1);
      check("s7_g6", 32'(g_hist[t0 + 6]), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024, number of idle cycles a granted client may stall mid-packet before its grant is revoked.
REQ-002 clk  input  1  system clock, 100 MHz nominal; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  client 0 has a byte on req0_data.
REQ-005 req0_data  input  8  client 0 byte.
REQ-006 req0_last  input  1  the req0_data byte is the final byte of client 0's packet.
REQ-007 req0_ready  output  1  client 0 byte is accepted this cycle when req0_valid is also high.
REQ-008 req1_valid, req1_data, req1_last, req1_ready  same directions, widths and meanings as the client 0 ports, for client 1.
REQ-009 tx_full  input  1  UART transmit FIFO full flag.
REQ-010 wr_uart  output  1  single-cycle write strobe to the UART transmit FIFO.
REQ-011 w_data  output  8  byte written to the UART transmit FIFO.
REQ-012 grant  output  2  one-hot current owner: 01 means client 0, 10 means client 1, 00 means idle.
REQ-013 abort  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 The FSM SHALL have three states: IDLE, GNT0 and GNT1; grant SHALL equal 00, 01 and 10 respectively.
REQ-015 In IDLE, if exactly one reqN_valid is high, the next state SHALL be GNTn.
REQ-016 In IDLE, if both valids are high, the grant SHALL go to the client not recorded in last_owner (round-robin).
REQ-017 In IDLE with no valid, the FSM SHALL stay in IDLE; arbitration costs exactly one cycle, and no byte transfers in IDLE.
REQ-018 In GNTn, a transfer SHALL occur in any cycle where reqN_valid=1 and tx_full=0.
REQ-019 During a transfer: reqN_ready=1, wr_uart=1 and w_data=reqN_data, all combinational in the same cycle.
REQ-020 reqN_ready SHALL equal (state==GNTn) AND NOT tx_full; the non-granted client's ready SHALL be 0.
REQ-021 wr_uart SHALL never be asserted while tx_full=1; no byte is dropped or duplicated.
REQ-022 When w_data is not being written it SHALL be 8'h00.
REQ-023 A transfer with reqN_last=1 SHALL move GNTn to IDLE on the next edge and set last_owner=n.
REQ-024 A packet is never interleaved: the grant is held through any number of bytes until last or timeout.
REQ-025 A 16-bit idle counter SHALL clear on entry to GNTn and on every transfer.
REQ-026 The idle counter SHALL increment in GNTn cycles with reqN_valid=0 and SHALL hold while stalled by tx_full with valid=1.
REQ-027 When the idle counter reaches TIMEOUT-1 with valid still low, the next state SHALL be IDLE, last_owner=n, and abort SHALL pulse high for exactly the following cycle.
REQ-028 A valid arriving in the same cycle the counter reaches TIMEOUT-1 SHALL win: the transfer occurs and no abort is generated.
REQ-029 The other client's valid SHALL have no effect on a GNTn state; it waits for IDLE.
REQ-030 A last-byte transfer while the other client is waiting SHALL lead to IDLE, then the other client is granted in the cycle after.

Reset
REQ-031 While reset is high at a clock edge: state=IDLE, last_owner=1 (client 0 wins the first tie), idle counter=0, abort=0.
REQ-032 After reset: grant=00, wr_uart=0, w_data=8'h00, req0_ready=0, req1_ready=0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet without an abort pulse; a byte offered in the reset cycle SHALL NOT be written.

Verification
REQ-034 Scenario: after reset, client 0 sends packet 55,AA(last) with tx_full=0 -> grant=01 one cycle after valid; two wr_uart pulses with w_data 55 then AA; grant=00 after.
REQ-035 Scenario: both clients valid in the same cycle after reset, client 0 sends F0(last) and client 1 sends 0F(last) -> client 0 granted first, then IDLE, then client 1; writes in order F0, 0F.
REQ-036 Scenario: tx_full=1 for 50 cycles mid-packet with valid held -> no wr_uart and ready=0 throughout; no abort; transfer resumes the cycle after tx_full falls.
REQ-037 Scenario: TIMEOUT=8, client 1 sends FF without last then drops valid -> abort pulses once 8 idle cycles later; grant=00; a waiting client 0 is granted next.
REQ-038 Scenario: client 0 streams 4 bytes 01..04 (04 last) while client 1 is valid throughout -> no client 1 byte is interleaved; client 1 is granted the second cycle after 04 is written.
REQ-039 Scenario: reset pulsed while grant=01 mid-packet -> grant=00 and wr_uart=0 the cycle after; no abort; the next tie goes to client 0.
